scan_sequencer: RTL
===================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 The block SHALL have parameter DIV, default 4, giving the clock cycles per sequence step; legal range 1..256.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port start, input, 1 bit: leave IDLE and begin scanning.
REQ-005 The block SHALL have port stop, input, 1 bit: return to IDLE; highest priority.
REQ-006 The block SHALL have port hold, input, 1 bit: freeze the scan while high.
REQ-007 The block SHALL have port step, input, 1 bit: single-advance request, honoured only in HOLD.
REQ-008 The block SHALL have port dir, input, 1 bit: 0 = count up, 1 = count down.
REQ-009 The block SHALL have port sel, output, 3 bits: scan index driving the downstream 3-to-8 decoder select.
REQ-010 The block SHALL have port sel_en, output, 1 bit: drives the decoder enable; 1 in RUN and HOLD.
REQ-011 The block SHALL have port wrap, output, 1 bit: one-cycle pulse at a sequence boundary.

Function
REQ-012 The block SHALL register all outputs; no combinational path from any input to any output.
REQ-013 The block SHALL implement states IDLE, RUN and HOLD.
REQ-014 Transitions SHALL be evaluated in this priority order:
- stop=1: any state -> IDLE.
- IDLE: start=1 -> RUN.
- RUN: hold=1 -> HOLD.
- HOLD: hold=0 -> RUN.
- start in RUN or HOLD: ignored.
REQ-015 In IDLE the block SHALL hold sel=0, sel_en=0, wrap=0 and the prescaler at 0.
REQ-016 In RUN the prescaler SHALL count 0..DIV-1; the tick is the cycle at DIV-1; the prescaler SHALL return to 0 after the tick.
REQ-017 On entering RUN from any state the prescaler SHALL be cleared, so the first advance occurs exactly DIV cycles after the entry edge.
REQ-018 Advance rule: on each tick, sel SHALL become (sel+1) mod 8 if dir=0, or (sel-1) mod 8 if dir=1.
REQ-019 Wrap pulse: wrap SHALL be 1 for exactly the cycle in which sel transitions 7->0 or 0->7.
REQ-020 In HOLD, sel and the prescaler SHALL be frozen and sel_en SHALL remain 1.
REQ-021 Step: step=1 in HOLD SHALL advance sel by one position per REQ-018 at the next edge, with the wrap rule of REQ-019 applied; step outside HOLD SHALL be ignored.
REQ-022 Entry latency: sel_en SHALL become 1 on the same edge that samples start=1, and 0 on the edge that samples stop=1.
REQ-023 A change of dir mid-scan SHALL take effect at the next tick or step.
REQ-024 If stop and start are high in the same cycle, stop SHALL win; if stop and step are high in the same cycle, stop SHALL win.
REQ-025 If hold and a tick coincide in RUN, the tick advance SHALL occur and the block SHALL enter HOLD on the same edge.

Reset
REQ-026 When rst_n=0 at a rising edge, the block SHALL go to state IDLE with sel=0, sel_en=0, wrap=0 and prescaler=0, regardless of the current state.
REQ-027 Reset asserted mid-RUN or mid-HOLD SHALL discard all scan progress; no pending tick or step SHALL survive the reset.

Configuration
REQ-028 The block SHALL support macro SCAN_BOUNCE_EN.
- With SCAN_BOUNCE_EN defined: ping-pong mode.
  - Scan direction is internal, loaded from dir on the IDLE->RUN edge; dir is ignored otherwise.
  - Direction reverses on reaching 7 (counting up) or 0 (counting down).
  - wrap pulses in the cycle sel reaches either end.
  - sel never jumps 7<->0.
- Without SCAN_BOUNCE_EN: modulo-8 behaviour per REQ-018 and REQ-019, with dir live.

Verification
REQ-029 Reset: rst_n=0 for 2 cycles during RUN with sel=5 -> sel=0, sel_en=0, wrap=0 after the first reset edge; the block stays in IDLE with start=0.
REQ-030 Up scan (DIV=4, dir=0): start pulse -> sel_en=1 next edge; sel steps 0,1,...,7 every 4 cycles; 7->0 at cycle 32 with wrap=1 for one cycle.
REQ-031 Down scan (DIV=4, dir=1): start from sel=0 -> first tick gives sel=7 with wrap=1; the next tick gives sel=6 with wrap=0.
REQ-032 Hold/step (DIV=4): hold=1 at sel=3 -> sel stays 3 for 20 cycles with sel_en=1; a step pulse gives sel=4 next edge; hold released -> sel=5 exactly 4 cycles later.
REQ-033 Priority: stop=1 and start=1 in IDLE -> remain IDLE; stop=1 and step=1 in HOLD at sel=6 -> IDLE with sel=0 and no advance.
REQ-034 SCAN_BOUNCE_EN (DIV=1, dir=0): sel sequence 0..7,6,5,...,0,1; wrap=1 at the cycles sel=7 and sel=0; changing dir mid-scan has no effect.

Source files
------------

// File: rtl/scan_sequencer.sv
// Scan sequencer: walks a 3-bit decoder select through 0..7, one step every DIV clocks,
// with hold/single-step control. Define SCAN_BOUNCE_EN for ping-pong scanning instead of modulo-8.
module scan_sequencer #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       hold,
  input  logic       step,
  input  logic       dir,
  output logic [2:0] sel,
  output logic       sel_en,
  output logic       wrap
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [2:0]    next_sel;
  logic          next_wrap;
  logic          tick;

  assign tick = (presc == PRESC_LAST);

`ifdef SCAN_BOUNCE_EN
  logic dir_q;
  logic eff_dir;

  // The ends force the direction, so sel can never jump between 7 and 0.
  always_comb begin
    eff_dir = dir_q;
    if (sel == 3'd7) eff_dir = 1'b1;
    else if (sel == 3'd0) eff_dir = 1'b0;
    next_sel  = eff_dir ? sel - 3'd1 : sel + 3'd1;
    next_wrap = (next_sel == 3'd7) || (next_sel == 3'd0);
  end
`else
  always_comb begin
    next_sel  = dir ? sel - 3'd1 : sel + 3'd1;
    next_wrap = dir ? (sel == 3'd0) : (sel == 3'd7);
  end
`endif

  // NOTE: state is updated with non-blocking assignments only, so every branch
  // below reads the pre-edge values of sel/presc regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || stop) begin
      state  <= IDLE;
      sel    <= 3'd0;
      sel_en <= 1'b0;
      wrap   <= 1'b0;
      presc  <= '0;
`ifdef SCAN_BOUNCE_EN
      dir_q  <= 1'b0;
`endif
    end else begin
      wrap <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            sel_en <= 1'b1;
            presc  <= '0;
`ifdef SCAN_BOUNCE_EN
            dir_q  <= dir;
`endif
          end
        end
        RUN: begin
          if (tick) begin
            presc <= '0;
            sel   <= next_sel;
            wrap  <= next_wrap;
`ifdef SCAN_BOUNCE_EN
            dir_q <= eff_dir;
`endif
          end else begin
            presc <= presc + PW'(1);
          end
          if (hold) state <= HOLD;
        end
        HOLD: begin
          if (step) begin
            sel   <= next_sel;
            wrap  <= next_wrap;
`ifdef SCAN_BOUNCE_EN
            dir_q <= eff_dir;
`endif
          end
          // Re-entering RUN restarts the prescaler so the next advance is a full DIV away.
          if (!hold) begin
            state <= RUN;
            presc <= '0;
          end
        end
        default: begin
          state  <= IDLE;
          sel    <= 3'd0;
          sel_en <= 1'b0;
          presc  <= '0;
        end
      endcase
    end
  end

endmodule
